// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcodes, ALU ops, mux codes.
package mc_ctrl_fsm_pkg;

  // FSM state encodings
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // Instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instr[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;

  // PC source and immediate-extension selects
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] EXT_SIGN  = 2'd0;
  localparam logic [1:0] EXT_ZERO  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                       (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // lui adds the upper-extended immediate to $0 (rs field is zero)
  function automatic logic [3:0] alu_op(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SUB:  return ALU_SUB;
          FN_AND:  return ALU_AND;
          FN_OR:   return ALU_OR;
          FN_SLT:  return ALU_SLT;
          default: return ALU_ADD;
        endcase
      end
      OP_BEQ:  return ALU_SUB;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_timer.sv
// Wait-state watchdog: counts non-ack cycles, flags expiry on the last allowed one.
module mc_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear wins over increment; FSM leaves the wait state on expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (TIMEOUT_CYC != 0) && inc && (cnt_q == LAST);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes, watchdog,
// illegal-op trap and retire counter.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funccode,
  input  logic                 zero,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic [1:0]           ext_mode,
  output logic                 illegal,
  output logic                 timeout,
  output logic [CNT_W-1:0]     retired
);
  logic [2:0]       state_q, state_d;
  logic [5:0]       op_q, op_d, fn_q, fn_d;
  logic             illegal_q, illegal_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             tmr_clr, tmr_inc, tmr_exp;

  mc_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk(clk), .rstn(rstn), .clr(tmr_clr), .inc(tmr_inc), .expired(tmr_exp)
  );

  // next-state, sticky flags, retire count and watchdog control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retired_d = retired_q;
    tmr_inc   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
        else begin
          tmr_inc = 1'b1;
          if (tmr_exp) begin state_d = S_ERR; timeout_d = 1'b1; end
        end
      end
      S_DECODE: begin
        op_d = opcode;
        fn_d = funccode;
        if (is_supported(opcode, funccode)) state_d = S_EXEC;
        else begin state_d = S_ERR; illegal_d = 1'b1; end
      end
      S_EXEC: begin
        case (op_q)
          OP_BEQ, OP_J: state_d = S_FETCH;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
        else begin
          tmr_inc = 1'b1;
          if (tmr_exp) begin state_d = S_ERR; timeout_d = 1'b1; end
        end
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
      retired_d = retired_q + CNT_W'(1);
    tmr_clr = (state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM);
  end

  // state and sticky registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  // control outputs from state and latched instruction; fetch strobes follow imem_ack
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SEQ;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_ctrl   = '0;
    ext_mode   = EXT_SIGN;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_ctrl   = ALUCTRL_W'(alu_op(op_q, fn_q));
      alu_src_b  = (op_q != OP_RTYPE) && (op_q != OP_BEQ) && (op_q != OP_J);
      reg_dst    = (op_q == OP_RTYPE);
      mem_to_reg = (op_q == OP_LW);
      ext_mode   = (op_q == OP_ORI) ? EXT_ZERO : (op_q == OP_LUI) ? EXT_UPPER : EXT_SIGN;
    end
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        pc_we    = imem_ack;
      end
      S_EXEC: begin
        if (op_q == OP_BEQ) begin pc_we = zero; pc_src = PC_BRANCH; end
        if (op_q == OP_J)   begin pc_we = 1'b1; pc_src = PC_JUMP;   end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
      end
      S_WB:    reg_we = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm with a short watchdog and a 4-bit retire counter.
module tb_mc_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] opcode, funccode;
  logic       zero, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_b;
  logic [1:0] pc_src, ext_mode;
  logic [3:0] alu_ctrl;
  logic       illegal, timeout;
  logic [3:0] retired;
  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm #(.ALUCTRL_W(4), .TIMEOUT_CYC(4), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funccode(funccode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .ext_mode(ext_mode), .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL bench_time_limit observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // FETCH cycle with zero-wait ack; returns in DECODE with ack dropped
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funccode = fn; imem_ack = 1'b1;
    #1 chk("fetch_ir_we", 32'(ir_we), 1);
    chk("fetch_pc_we", 32'(pc_we), 1);
    step();
    imem_ack = 1'b0;
  endtask

  task automatic do_j();
    fetch(6'h02, 6'h00);
    step();
    step();
  endtask

  initial begin
    rstn = 1'b0; opcode = '0; funccode = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    #1 chk("rst_imem_req", 32'(imem_req), 1);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_flags", {30'd0, illegal, timeout}, 0);

    // add $3,$1,$2 zero-wait
    fetch(6'h00, 6'h20);
    #1 chk("add_dec_imem_req", 32'(imem_req), 0);
    step(); #1 chk("add_exec_alu", 32'(alu_ctrl), 2);
    chk("add_exec_srcb", 32'(alu_src_b), 0);
    chk("add_exec_reg_we", 32'(reg_we), 0);
    step(); #1 chk("add_wb_reg_we", 32'(reg_we), 1);
    chk("add_wb_reg_dst", 32'(reg_dst), 1);
    chk("add_wb_mem_to_reg", 32'(mem_to_reg), 0);
    step(); #1 chk("add_retired", 32'(retired), 1);
    chk("add_after_reg_we", 32'(reg_we), 0);

    // lw with dmem_ack three cycles late
    fetch(6'h23, 6'h00);
    step(); #1 chk("lw_exec_srcb", 32'(alu_src_b), 1);
    chk("lw_exec_alu", 32'(alu_ctrl), 2);
    step();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1 chk("lw_mem_req", 32'(dmem_req), 1);
      chk("lw_mem_we", 32'(dmem_we), 0);
      step();
    end
    dmem_ack = 1'b0;
    #1 chk("lw_wb_dmem_req", 32'(dmem_req), 0);
    chk("lw_wb_reg_we", 32'(reg_we), 1);
    chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
    step(); #1 chk("lw_after_reg_we", 32'(reg_we), 0);
    chk("lw_retired", 32'(retired), 2);

    // beq taken then not taken
    fetch(6'h04, 6'h00);
    step(); zero = 1'b1;
    #1 chk("beq_t_pc_we", 32'(pc_we), 1);
    chk("beq_t_pc_src", 32'(pc_src), 1);
    chk("beq_t_alu", 32'(alu_ctrl), 6);
    step(); zero = 1'b0;
    #1 chk("beq_t_fetch", 32'(imem_req), 1);
    chk("beq_t_retired", 32'(retired), 3);
    fetch(6'h04, 6'h00);
    step(); #1 chk("beq_n_pc_we", 32'(pc_we), 0);
    chk("beq_n_pc_src", 32'(pc_src), 1);
    step(); #1 chk("beq_n_fetch", 32'(imem_req), 1);
    chk("beq_n_retired", 32'(retired), 4);

    // j
    fetch(6'h02, 6'h00);
    step(); #1 chk("j_pc_we", 32'(pc_we), 1);
    chk("j_pc_src", 32'(pc_src), 2);
    step(); #1 chk("j_retired", 32'(retired), 5);

    // sw zero-wait
    fetch(6'h2B, 6'h00);
    step(); step(); dmem_ack = 1'b1;
    #1 chk("sw_mem_req", 32'(dmem_req), 1);
    chk("sw_mem_we", 32'(dmem_we), 1);
    chk("sw_mem_reg_we", 32'(reg_we), 0);
    step(); dmem_ack = 1'b0;
    #1 chk("sw_fetch_dmem_req", 32'(dmem_req), 0);
    chk("sw_retired", 32'(retired), 6);

    // ori and lui immediate handling
    fetch(6'h0D, 6'h00);
    step(); #1 chk("ori_alu", 32'(alu_ctrl), 1);
    chk("ori_srcb", 32'(alu_src_b), 1);
    chk("ori_ext", 32'(ext_mode), 1);
    step(); #1 chk("ori_wb_reg_we", 32'(reg_we), 1);
    chk("ori_wb_reg_dst", 32'(reg_dst), 0);
    step(); #1 chk("ori_retired", 32'(retired), 7);
    fetch(6'h0F, 6'h00);
    step(); #1 chk("lui_ext", 32'(ext_mode), 2);
    chk("lui_srcb", 32'(alu_src_b), 1);
    step(); step(); #1 chk("lui_retired", 32'(retired), 8);

    // retire counter wraps 15 -> 0
    repeat (7) do_j();
    #1 chk("wrap_15", 32'(retired), 15);
    do_j();
    #1 chk("wrap_0", 32'(retired), 0);

    // ack on the last allowed cycle wins over the watchdog
    for (int i = 0; i < 3; i++) begin
      #1 chk("late_ack_req", 32'(imem_req), 1);
      step();
    end
    fetch(6'h02, 6'h00);
    #1 chk("late_ack_timeout", 32'(timeout), 0);
    step(); step();
    #1 chk("late_ack_retired", 32'(retired), 1);
    chk("late_ack_fetch", 32'(imem_req), 1);

    // imem_ack stuck low: watchdog fires after 4 request cycles
    for (int i = 0; i < 4; i++) begin
      #1 chk("stuck_req", 32'(imem_req), 1);
      chk("stuck_no_timeout", 32'(timeout), 0);
      step();
    end
    #1 chk("stuck_timeout", 32'(timeout), 1);
    chk("stuck_req_dropped", 32'(imem_req), 0);
    step(); #1 chk("stuck_hold_timeout", 32'(timeout), 1);
    rstn = 1'b0;
    #1 chk("stuck_rst_timeout", 32'(timeout), 0);
    step(); rstn = 1'b1;

    // reset during sw MEM wait, late ack afterwards ignored
    do_j();
    #1 chk("pre_sw_retired", 32'(retired), 1);
    fetch(6'h2B, 6'h00);
    step(); step();
    #1 chk("sw_wait_req", 32'(dmem_req), 1);
    step();
    #2 rstn = 1'b0;
    #1 chk("rst_mid_dmem_req", 32'(dmem_req), 0);
    chk("rst_mid_retired", 32'(retired), 0);
    step(); rstn = 1'b1; dmem_ack = 1'b1;
    #1 chk("late_dack_dmem_req", 32'(dmem_req), 0);
    chk("late_dack_imem_req", 32'(imem_req), 1);
    step(); dmem_ack = 1'b0;
    #1 chk("after_rst_dmem_req", 32'(dmem_req), 0);
    chk("after_rst_retired", 32'(retired), 0);

    // unsupported opcode traps
    fetch(6'h3F, 6'h00);
    #1 chk("ill_decode_flag", 32'(illegal), 0);
    step(); imem_ack = 1'b1;
    #1 chk("ill_flag", 32'(illegal), 1);
    chk("ill_no_req", 32'(imem_req), 0);
    chk("ill_no_ir_we", 32'(ir_we), 0);
    step();
    #1 chk("ill_hold_flag", 32'(illegal), 1);
    chk("ill_hold_no_req", 32'(imem_req), 0);
    imem_ack = 1'b0;
    rstn = 1'b0;
    #1 chk("ill_rst_flag", 32'(illegal), 0);
    chk("ill_rst_req", 32'(imem_req), 1);
    step(); rstn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
